y_interp_ctrl: RTL and testbench
================================

# y_interp_ctrl

Sequencing controller for the vertical (y) pass of the bicubic interpolation datapath. It collects four horizontally interpolated row samples (8.7 fixed point, 15 bits) into a tap window and drives them as shared operands into the four y weight tables (phases 0–3). It then selects the table result matching the latched fractional phase and presents the 8-bit pixel on a valid/ready output. It sits between the x-pass output stream and the pixel writer, and matches the one-cycle registered latency of the weight tables.

## Interface
- No parameters; widths fixed by the datapath (15-bit samples, 8-bit pixels, 4 taps, 4 phases).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- row_in  in  15  x-pass sample, 8.7 fixed point, tap order 0..3.
- row_phase  in  2  y fractional phase; sampled only with tap 3.
- row_valid  in  1  row_in/row_phase valid.
- row_ready  out  1  controller accepts a sample this cycle.
- tbl_in_0..tbl_in_3  out  15 each  tap window, wired to in_0..in_3 of all four y weight tables.
- tbl_sum_0..tbl_sum_3  in  8 each  weight_sum of y weight tables phase 0..3.
- pix_out  out  8  interpolated pixel.
- pix_valid  out  1  pix_out valid.
- pix_ready  in  1  downstream accepts pix_out.

## Operation
- FSM states: LOAD, ISSUE, CAPTURE, OUT.
- LOAD:
  - row_ready=1.
  - Each accepted sample (row_valid&row_ready) writes win[tap_cnt] and increments the 2-bit tap_cnt.
  - The sample at tap_cnt=3 also latches row_phase into phase_q, wraps tap_cnt to 0, and moves the FSM to ISSUE.
- ISSUE:
  - row_ready=0.
  - Window held stable; the tables register their products at the end of this cycle.
  - Next state is always CAPTURE.
- CAPTURE:
  - row_ready=0.
  - pix_q <= tbl_sum_{phase_q}.
  - Next state is OUT in the base build; see Configuration for the buffered build.
- OUT:
  - pix_valid=1, row_ready=0.
  - On pix_ready, go to LOAD; otherwise hold, with pix_out stable.
- tbl_in_k = win[k] at all times (registered, no combinational path from row_in).
- No arithmetic in the block; table results pass through unmodified, so negative lobes wrap exactly as the tables produce them.
- Reset values: state=LOAD, tap_cnt=0, win[*]=0, phase_q=0, pix_q=0, pix_valid=0, row_ready=1 (LOAD).
- Reset asserted mid-group or mid-output discards partial window and any pending pixel; the first sample after release is tap 0.
- row_valid low in LOAD: no change; taps need not be contiguous in time.
- row_phase on taps 0–2 is ignored.

## Timing
- Tap-3 accept at edge E0: ISSUE during E0..E1, CAPTURE during E1..E2, pix_valid high from E2.
- Latency: 2 cycles from tap-3 accept to pix_valid.
- Throughput, base build with pix_ready tied 1: 4 LOAD + ISSUE + CAPTURE + OUT = 7 cycles per pixel.
- pix_out/pix_valid are register outputs; pix_out changes only when pix_valid=0 or on the cycle after a handshake.
- The valid/ready handshake completes on a rising edge with both high. pix_valid never drops without pix_ready.

## Configuration
- Macro: Y_INTERP_CTRL_OUTBUF_EN.
- Undefined (base build):
  - Single output register.
  - FSM stalls in OUT until pix_ready; no new taps are accepted while a pixel is pending.
- Defined (buffered build):
  - A 2-entry output FIFO replaces pix_q; state OUT is unused.
  - CAPTURE pushes the FIFO and returns to LOAD.
  - LOAD deasserts row_ready while the FIFO is full.
  - pix_valid = FIFO non-empty. A push and pop in the same cycle keep the count unchanged.
  - Throughput rises to 6 cycles per pixel.
  - Reset empties the FIFO.

## Test plan
- Reset, then taps 0x0080, 0x0100, 0x0180, 0x0200 with phase 2, and tables returning 0x11/0x22/0x33/0x44 -> tbl_in_0..3 show the taps, pix_out=0x33, pix_valid 2 cycles after the tap-3 edge, row_ready=0 until the handshake.
- pix_ready held 0 for 10 cycles after pix_valid -> pix_out stable at its value, pix_valid stays 1, row_ready=0 (base build); the FSM resumes LOAD on the cycle after pix_ready=1.
- row_valid toggled 1/0 during taps, row_phase=3 on taps 0–2 and 1 on tap 3 -> the phase 1 table is selected; bubbles only delay completion.
- rst pulsed low after tap 2 -> tap_cnt=0, pix_valid=0; the next 4 samples form a fresh group with a correct result.
- Back-to-back 8 groups with pix_ready=1 -> 8 pixels, one every 7 cycles (base) or 6 cycles (OUTBUF_EN), in phase order 0,1,2,3,0,1,2,3.
- OUTBUF_EN with pix_ready=0 for 3 groups -> the FIFO holds 2 pixels and row_ready stays 0 in LOAD after the second capture; on release the pixels drain in order.

Source files
------------

// File: rtl/y_interp_ctrl.sv
// Vertical-pass sequencer for bicubic interpolation: gathers a 4-tap window, waits out
// the weight-table latency, selects the phase result. Y_INTERP_CTRL_OUTBUF_EN adds a 2-entry output FIFO.
module y_interp_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] row_in,
  input  logic [1:0]  row_phase,
  input  logic        row_valid,
  output logic        row_ready,
  output logic [14:0] tbl_in_0,
  output logic [14:0] tbl_in_1,
  output logic [14:0] tbl_in_2,
  output logic [14:0] tbl_in_3,
  input  logic [7:0]  tbl_sum_0,
  input  logic [7:0]  tbl_sum_1,
  input  logic [7:0]  tbl_sum_2,
  input  logic [7:0]  tbl_sum_3,
  output logic [7:0]  pix_out,
  output logic        pix_valid,
  input  logic        pix_ready
);

  typedef enum logic [1:0] {LOAD = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, OUT = 2'd3} state_t;

  state_t      state_reg;
  logic [1:0]  tap_cnt_reg;
  logic [1:0]  phase_reg;
  logic        row_ready_reg;
  logic        pix_valid_reg;
  logic [7:0]  pix_reg;
  logic [7:0]  sum_sel;
  logic [14:0] win [4];
  logic        tap_accept;
  logic        tap_last;

  assign tap_accept = (state_reg == LOAD) && row_valid && row_ready_reg;
  assign tap_last   = tap_accept && (tap_cnt_reg == 2'd3);

  // One register per tap; only the slot addressed by tap_cnt loads.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
      logic [14:0] tap_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          tap_reg <= '0;
        else if (tap_accept && (tap_cnt_reg == 2'(gi)))
          tap_reg <= row_in;
      end
      assign win[gi] = tap_reg;
    end
  endgenerate

  assign tbl_in_0  = win[0];
  assign tbl_in_1  = win[1];
  assign tbl_in_2  = win[2];
  assign tbl_in_3  = win[3];
  assign row_ready = row_ready_reg;
  assign pix_valid = pix_valid_reg;
  assign pix_out   = pix_reg;

  always_comb begin
    sum_sel = tbl_sum_0;
    case (phase_reg)
      2'd1:    sum_sel = tbl_sum_1;
      2'd2:    sum_sel = tbl_sum_2;
      2'd3:    sum_sel = tbl_sum_3;
      default: sum_sel = tbl_sum_0;
    endcase
  end

`ifdef Y_INTERP_CTRL_OUTBUF_EN
  logic [7:0] tail_reg;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;
  logic       push;
  logic       pop;

  assign push     = (state_reg == CAPTURE);
  assign pop      = pix_valid_reg && pix_ready;
  assign cnt_next = cnt_reg + 2'(push) - 2'(pop);

  // pix_reg is the FIFO head so pix_out stays a plain register output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_reg       <= '0;
      tail_reg      <= '0;
      cnt_reg       <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      if (push && pop) begin
        if (cnt_reg == 2'd2) begin
          pix_reg  <= tail_reg;
          tail_reg <= sum_sel;
        end else begin
          pix_reg <= sum_sel;
        end
      end else if (push) begin
        if (cnt_reg == 2'd0)
          pix_reg <= sum_sel;
        else
          tail_reg <= sum_sel;
      end else if (pop && (cnt_reg == 2'd2)) begin
        pix_reg <= tail_reg;
      end
      cnt_reg       <= cnt_next;
      pix_valid_reg <= (cnt_next != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOAD;
      tap_cnt_reg   <= '0;
      phase_reg     <= '0;
      row_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        LOAD: begin
          if (tap_accept)
            tap_cnt_reg <= tap_cnt_reg + 2'd1;
          if (tap_last) begin
            phase_reg <= row_phase;
            state_reg <= ISSUE;
          end
          row_ready_reg <= !tap_last && (cnt_next != 2'd2);
        end
        ISSUE:   state_reg <= CAPTURE;
        CAPTURE: begin
          state_reg     <= LOAD;
          row_ready_reg <= (cnt_next != 2'd2);
        end
        default: begin
          state_reg     <= LOAD;
          row_ready_reg <= (cnt_next != 2'd2);
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOAD;
      tap_cnt_reg   <= '0;
      phase_reg     <= '0;
      pix_reg       <= '0;
      pix_valid_reg <= 1'b0;
      row_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        LOAD: begin
          if (tap_accept)
            tap_cnt_reg <= tap_cnt_reg + 2'd1;
          if (tap_last) begin
            phase_reg     <= row_phase;
            state_reg     <= ISSUE;
            row_ready_reg <= 1'b0;
          end
        end
        ISSUE:   state_reg <= CAPTURE;
        CAPTURE: begin
          pix_reg       <= sum_sel;
          pix_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid_reg <= 1'b0;
            row_ready_reg <= 1'b1;
            state_reg     <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_y_interp_ctrl.sv
// Directed bench for y_interp_ctrl; covers the base build and, with
// Y_INTERP_CTRL_OUTBUF_EN defined, the buffered build.
module tb_y_interp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] row_in = '0;
  logic [1:0]  row_phase = '0;
  logic        row_valid = 1'b0;
  logic        row_ready;
  logic [14:0] tbl_in_0, tbl_in_1, tbl_in_2, tbl_in_3;
  logic [7:0]  tbl_sum_0 = 8'h11, tbl_sum_1 = 8'h22, tbl_sum_2 = 8'h33, tbl_sum_3 = 8'h44;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        pix_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef Y_INTERP_CTRL_OUTBUF_EN
  localparam int   PERIOD  = 6;
  localparam logic RR_PEND = 1'b1;
`else
  localparam int   PERIOD  = 7;
  localparam logic RR_PEND = 1'b0;
`endif

  y_interp_ctrl dut (
    .clk(clk), .rst(rst),
    .row_in(row_in), .row_phase(row_phase), .row_valid(row_valid), .row_ready(row_ready),
    .tbl_in_0(tbl_in_0), .tbl_in_1(tbl_in_1), .tbl_in_2(tbl_in_2), .tbl_in_3(tbl_in_3),
    .tbl_sum_0(tbl_sum_0), .tbl_sum_1(tbl_sum_1), .tbl_sum_2(tbl_sum_2), .tbl_sum_3(tbl_sum_3),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one tap from a negedge and returns on the negedge after it is accepted.
  task automatic send_tap(input logic [14:0] d, input logic [1:0] p);
    int n;
    n = 0;
    row_in = d; row_phase = p; row_valid = 1'b1;
    while (!row_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("tap_timeout", 16'd1, 16'd0);
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic send_group(input logic [14:0] t0, input logic [14:0] t1,
                            input logic [14:0] t2, input logic [14:0] t3, input logic [1:0] p);
    send_tap(t0, 2'd0);
    send_tap(t1, 2'd0);
    send_tap(t2, 2'd0);
    send_tap(t3, p);
  endtask

  task automatic wait_pix(input string tag);
    int n;
    n = 0;
    while (!pix_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({tag, "_timeout"}, 16'd1, 16'd0);
  endtask

  task automatic pop_pix(input string tag, input logic [7:0] exp);
    wait_pix(tag);
    check(tag, {8'd0, pix_out}, {8'd0, exp});
    $display("pixel %s out=%02h", tag, pix_out);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
  endtask

  task automatic drive_groups(input int ng);
    for (int g = 0; g < ng; g++)
      send_group(15'(g * 4), 15'(g * 4 + 1), 15'(g * 4 + 2), 15'(g * 4 + 3), 2'(g % 4));
  endtask

  task automatic monitor_pix(input int ng);
    logic [7:0] exp_tab [4];
    int last;
    int n;
    exp_tab[0] = 8'h11; exp_tab[1] = 8'h22; exp_tab[2] = 8'h33; exp_tab[3] = 8'h44;
    last = 0;
    for (int k = 0; k < ng; k++) begin
      n = 0;
      while (!pix_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) check("b2b_timeout", 16'd1, 16'd0);
      check("b2b_pix", {8'd0, pix_out}, {8'd0, exp_tab[k % 4]});
      if (k > 0) check("b2b_period", 16'(cyc - last), 16'(PERIOD));
      $display("pixel b2b %0d out=%02h cycle=%0d", k, pix_out, cyc);
      last = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row_ready", {15'd0, row_ready}, 16'd1);
    check("rst_pix_valid", {15'd0, pix_valid}, 16'd0);
    check("rst_pix_out", {8'd0, pix_out}, 16'd0);
    check("rst_tbl_in_0", {1'b0, tbl_in_0}, 16'd0);
    rst = 1'b1;

    // Basic group, phase 2, and the two-cycle latency
    send_group(15'h0080, 15'h0100, 15'h0180, 15'h0200, 2'd2);
    check("t1_tbl_in_0", {1'b0, tbl_in_0}, 16'h0080);
    check("t1_tbl_in_1", {1'b0, tbl_in_1}, 16'h0100);
    check("t1_tbl_in_2", {1'b0, tbl_in_2}, 16'h0180);
    check("t1_tbl_in_3", {1'b0, tbl_in_3}, 16'h0200);
    check("t1_valid_e0", {15'd0, pix_valid}, 16'd0);
    check("t1_ready_e0", {15'd0, row_ready}, 16'd0);
    @(negedge clk);
    check("t1_valid_e1", {15'd0, pix_valid}, 16'd0);
    @(negedge clk);
    check("t1_valid_e2", {15'd0, pix_valid}, 16'd1);
    check("t1_pix", {8'd0, pix_out}, 16'h0033);
    check("t1_ready_pend", {15'd0, row_ready}, {15'd0, RR_PEND});
    $display("pixel t1 out=%02h", pix_out);

    // Backpressure: output holds for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_pix", {8'd0, pix_out}, 16'h0033);
      check("t2_hold_valid", {15'd0, pix_valid}, 16'd1);
      check("t2_hold_ready", {15'd0, row_ready}, {15'd0, RR_PEND});
    end
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    check("t2_valid_after", {15'd0, pix_valid}, 16'd0);
    check("t2_ready_after", {15'd0, row_ready}, 16'd1);

    // Bubbles between taps, phase ignored on taps 0-2
    tbl_sum_0 = 8'h5A; tbl_sum_1 = 8'hA5; tbl_sum_2 = 8'h3C; tbl_sum_3 = 8'hC3;
    send_tap(15'h1111, 2'd3); @(negedge clk);
    send_tap(15'h2222, 2'd3); @(negedge clk); @(negedge clk);
    send_tap(15'h3333, 2'd3); @(negedge clk);
    send_tap(15'h4444, 2'd1);
    check("t3_tbl_in_0", {1'b0, tbl_in_0}, 16'h1111);
    check("t3_tbl_in_3", {1'b0, tbl_in_3}, 16'h4444);
    pop_pix("t3_pix", 8'hA5);

    // Reset after tap 2 discards the partial window
    send_tap(15'h0111, 2'd0);
    send_tap(15'h0222, 2'd0);
    send_tap(15'h0333, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_valid", {15'd0, pix_valid}, 16'd0);
    check("t4_ready", {15'd0, row_ready}, 16'd1);
    check("t4_tbl_in_0", {1'b0, tbl_in_0}, 16'd0);
    check("t4_tbl_in_2", {1'b0, tbl_in_2}, 16'd0);
    rst = 1'b1;
    send_group(15'h7FFF, 15'h4000, 15'h0001, 15'h1234, 2'd0);
    check("t4_tbl_in_0_new", {1'b0, tbl_in_0}, 16'h7FFF);
    check("t4_tbl_in_1_new", {1'b0, tbl_in_1}, 16'h4000);
    check("t4_tbl_in_3_new", {1'b0, tbl_in_3}, 16'h1234);
    pop_pix("t4_pix", 8'h5A);

    // Back-to-back groups with pix_ready held high
    tbl_sum_0 = 8'h11; tbl_sum_1 = 8'h22; tbl_sum_2 = 8'h33; tbl_sum_3 = 8'h44;
    pix_ready = 1'b1;
    fork
      drive_groups(8);
      monitor_pix(8);
    join
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);

`ifdef Y_INTERP_CTRL_OUTBUF_EN
    // FIFO fills to two entries, then drains in order
    send_group(15'h0010, 15'h0020, 15'h0030, 15'h0040, 2'd3);
    send_group(15'h0050, 15'h0060, 15'h0070, 15'h0080, 2'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("t6_full_ready", {15'd0, row_ready}, 16'd0);
      check("t6_full_valid", {15'd0, pix_valid}, 16'd1);
      check("t6_full_head", {8'd0, pix_out}, 16'h0044);
      @(negedge clk);
    end
    fork
      send_group(15'h0090, 15'h00A0, 15'h00B0, 15'h00C0, 2'd1);
      begin
        pop_pix("t6_pix_a", 8'h44);
        pop_pix("t6_pix_b", 8'h11);
        pop_pix("t6_pix_c", 8'h22);
      end
    join
    @(negedge clk);
    check("t6_empty_valid", {15'd0, pix_valid}, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
